// File: rtl/mem_arbiter_pkg.sv
// Shared constants and types for the fetch/data memory arbiter.
package mem_arbiter_pkg;

    localparam int DEF_TIMEOUT = 16;

    // RISC-V load/store funct3 encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_e;

    typedef enum logic {
        WIN_FETCH = 1'b0,
        WIN_DATA  = 1'b1
    } winner_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signals of the arbiter bundled into one interface.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Requests: *_req is held with its fields until the matching *_gnt is seen
    // high in the same cycle; completion is a single-cycle *_rvalid with *_err
    // and *_rdata. Memory: mem_req with stable fields until a mem_ready cycle.
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              if_err;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [2:0]        d_funct3;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic              d_err;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_funct3, d_wdata,
               mem_ready, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, if_err,
               d_gnt, d_rvalid, d_rdata, d_err,
               mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_funct3, d_wdata,
               mem_ready, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, if_err,
               d_gnt, d_rvalid, d_rdata, d_err,
               mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );

endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane handling for one access: enables, store replication, load
// extraction/extension and the misalign/illegal-funct3 checks.
module mem_lane_align
    import mem_arbiter_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext,
    output logic        misaligned,
    output logic        illegal
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        be         = 4'b1111;
        wdata_rep  = wdata;
        rdata_ext  = rdata;
        misaligned = 1'b0;
        illegal    = 1'b0;
        byte_sel   = rdata[{addr_lo, 3'b000} +: 8];
        half_sel   = rdata[{addr_lo[1], 4'b0000} +: 16];

        // Low funct3 bits give the access size for both loads and stores.
        case (funct3[1:0])
            2'b01:   misaligned = addr_lo[0];
            2'b10:   misaligned = (addr_lo != 2'b00);
            default: misaligned = 1'b0;
        endcase

        if (we) begin
            illegal = (funct3 > F3_SW);
            case (funct3)
                F3_SB: begin
                    be        = 4'b0001 << addr_lo;
                    wdata_rep = {4{wdata[7:0]}};
                end
                F3_SH: begin
                    be        = 4'b0011 << {addr_lo[1], 1'b0};
                    wdata_rep = {2{wdata[15:0]}};
                end
                default: begin
                    be        = 4'b1111;
                    wdata_rep = wdata;
                end
            endcase
        end else begin
            illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
            case (funct3)
                F3_LB:   rdata_ext = {{24{byte_sel[7]}}, byte_sel};
                F3_LBU:  rdata_ext = {24'h0, byte_sel};
                F3_LH:   rdata_ext = {{16{half_sel[15]}}, half_sel};
                F3_LHU:  rdata_ext = {16'h0, half_sel};
                default: rdata_ext = rdata;
            endcase
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and data load/store,
// one access in flight, alternating priority on conflicts.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus,
    output arb_state_e   dbg_state
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    arb_state_e        state_q, state_d;
    winner_e           last_q, last_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [2:0]        f3_q, f3_d;
    logic [3:0]        be_q, be_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    winner_e           win;
    logic              grant;
    logic [ADDR_W-1:0] win_addr;
    logic              win_we;
    logic [2:0]        win_f3;
    logic              in_idle;
    logic              al_we;
    logic [2:0]        al_f3;
    logic [1:0]        al_addr_lo;
    logic [3:0]        al_be;
    logic [31:0]       al_wdata;
    logic [31:0]       al_rdata;
    logic              al_misaligned;
    logic              al_illegal;
    logic              if_gnt_c, d_gnt_c;
    logic              mem_active, resp;
    logic              if_rvalid_c, d_rvalid_c;

    // Winner selection and aligner input: live request fields while IDLE,
    // latched fields once the access is underway. Fetch behaves like an LW.
    always_comb begin
        grant = bus.if_req | bus.d_req;
        win   = WIN_FETCH;
        if (bus.if_req && bus.d_req) begin
            win = (last_q == WIN_FETCH) ? WIN_DATA : WIN_FETCH;
        end else if (bus.d_req) begin
            win = WIN_DATA;
        end
        win_addr   = (win == WIN_DATA) ? bus.d_addr : bus.if_addr;
        win_we     = (win == WIN_DATA) & bus.d_we;
        win_f3     = (win == WIN_DATA) ? bus.d_funct3 : F3_LW;
        in_idle    = (state_q == ST_IDLE);
        al_we      = in_idle ? win_we : we_q;
        al_f3      = in_idle ? win_f3 : f3_q;
        al_addr_lo = in_idle ? win_addr[1:0] : addr_q[1:0];
    end

    mem_lane_align u_align (
        .we         (al_we),
        .funct3     (al_f3),
        .addr_lo    (al_addr_lo),
        .wdata      (bus.d_wdata),
        .rdata      (bus.mem_rdata),
        .be         (al_be),
        .wdata_rep  (al_wdata),
        .rdata_ext  (al_rdata),
        .misaligned (al_misaligned),
        .illegal    (al_illegal)
    );

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        addr_d   = addr_q;
        we_d     = we_q;
        f3_d     = f3_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        if_gnt_c = 1'b0;
        d_gnt_c  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (grant && !rst) begin
                    if_gnt_c = (win == WIN_FETCH);
                    d_gnt_c  = (win == WIN_DATA);
                    last_d   = win;
                    addr_d   = win_addr;
                    we_d     = win_we;
                    f3_d     = win_f3;
                    be_d     = al_be;
                    wdata_d  = al_wdata;
                    rdata_d  = '0;
                    cnt_d    = '0;
                    // Bad requests complete with an error without touching memory.
                    if (al_misaligned || al_illegal) begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        err_d   = 1'b0;
                        state_d = ST_ACCESS;
                    end
                end
            end
            ST_ACCESS: begin
                if (bus.mem_ready) begin
                    rdata_d = we_q ? '0 : al_rdata;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            last_q  <= WIN_FETCH;
            addr_q  <= '0;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            be_q    <= 4'b0000;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Memory fields are gated so the bus reads all-zero outside ACCESS.
    always_comb begin
        mem_active  = (state_q == ST_ACCESS);
        resp        = (state_q == ST_RESP);
        if_rvalid_c = resp && (last_q == WIN_FETCH);
        d_rvalid_c  = resp && (last_q == WIN_DATA);
    end

    assign bus.if_gnt    = if_gnt_c;
    assign bus.d_gnt     = d_gnt_c;
    assign bus.mem_req   = mem_active;
    assign bus.mem_we    = mem_active & we_q;
    assign bus.mem_addr  = mem_active ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign bus.mem_be    = mem_active ? be_q : 4'b0000;
    assign bus.mem_wdata = mem_active ? wdata_q : '0;
    assign bus.if_rvalid = if_rvalid_c;
    assign bus.if_rdata  = if_rvalid_c ? rdata_q : '0;
    assign bus.if_err    = if_rvalid_c & err_q;
    assign bus.d_rvalid  = d_rvalid_c;
    assign bus.d_rdata   = d_rvalid_c ? rdata_q : '0;
    assign bus.d_err     = d_rvalid_c & err_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised and directed checks of mem_arbiter against a spec-level model.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int TMO = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    arb_state_e dbg_state;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    // Pending requests seen by the reference
    bit          if_pend, d_pend;
    logic [31:0] if_a, d_a, d_wd;
    bit          d_we_v;
    logic [2:0]  d_f3;
    bit          last_data;

    // Values observed during the most recent serve, for directed checks
    bit          cap_d_won, cap_err, cap_we;
    logic [31:0] cap_rd, cap_addr, cap_wdata;
    logic [3:0]  cap_be;
    int          cap_req_cycles;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Expected outcome of one access computed from the access-size rules.
    function automatic void model(input bit is_d, input bit we, input logic [2:0] f3,
                                  input logic [31:0] addr, input logic [31:0] wd,
                                  input logic [31:0] word, input int lat,
                                  output bit err, output logic [3:0] be,
                                  output logic [31:0] wdo, output logic [31:0] rdo);
        int sz, off;
        bit legal, sgn;
        logic [31:0] v;
        off = int'(addr % 4);
        sgn = 1'b0;
        if (!is_d) begin
            sz = 4; legal = 1'b1;
        end else if (we) begin
            legal = (f3 < 3);
            sz = 1 << f3[1:0];
        end else begin
            legal = (f3 != 3) && (f3 < 6);
            sz = 1 << f3[1:0];
            sgn = (f3 < 4);
        end
        err = !legal || ((off % sz) != 0);
        if (!err && lat > TMO) err = 1'b1;
        be = we ? 4'(((1 << sz) - 1) << off) : 4'hF;
        for (int j = 0; j < 4; j++) wdo[8*j +: 8] = wd[8*(j % sz) +: 8];
        v = word >> (8 * off);
        if (sz == 1) v = sgn ? {{24{v[7]}}, v[7:0]} : {24'h0, v[7:0]};
        else if (sz == 2) v = sgn ? {{16{v[15]}}, v[15:0]} : {16'h0, v[15:0]};
        rdo = (err || we) ? 32'h0 : v;
    endfunction

    task automatic set_fetch(input logic [31:0] a);
        if_pend = 1'b1; if_a = a;
    endtask

    task automatic set_data(input bit we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        d_pend = 1'b1; d_we_v = we; d_f3 = f3; d_a = a; d_wd = wd;
    endtask

    // Present pending requests at a falling edge in IDLE and follow one access to completion.
    task automatic serve(input int lat, input logic [31:0] word);
        bit wd, err, we_x;
        logic [3:0] be;
        logic [31:0] wdo, rdo, a;
        bus.if_req   = if_pend;
        bus.if_addr  = if_a;
        bus.d_req    = d_pend;
        bus.d_we     = d_we_v;
        bus.d_addr   = d_a;
        bus.d_funct3 = d_f3;
        bus.d_wdata  = d_wd;
        wd = (if_pend && d_pend) ? !last_data : d_pend;
        #1;
        check("if_gnt", bus.if_gnt, !wd);
        check("d_gnt", bus.d_gnt, wd);
        cap_d_won = bus.d_gnt;
        a = wd ? d_a : if_a;
        we_x = wd & d_we_v;
        model(wd, we_x, d_f3, a, d_wd, word, lat, err, be, wdo, rdo);
        exp_q.push_back(rdo);
        last_data = wd;
        cap_req_cycles = 0; cap_be = 4'h0; cap_wdata = 32'h0; cap_addr = 32'h0; cap_we = 1'b0;
        @(posedge clk); @(negedge clk);
        if (wd) begin d_pend = 1'b0; bus.d_req = 1'b0; end
        else begin if_pend = 1'b0; bus.if_req = 1'b0; end
        if (!((wd && (d_we_v ? d_f3 > 2 : (d_f3 == 3 || d_f3 > 5))) || (a % 4) % ((wd ? (1 << d_f3[1:0]) : 4)) != 0)) begin
            for (int i = 1; i <= TMO; i++) begin
                cap_req_cycles += int'(bus.mem_req);
                if (i == 1) begin
                    cap_be = bus.mem_be; cap_wdata = bus.mem_wdata;
                    cap_addr = bus.mem_addr; cap_we = bus.mem_we;
                end
                check("mem_req", bus.mem_req, 1'b1);
                check("mem_addr", bus.mem_addr, a & ~32'h3);
                check("mem_be", bus.mem_be, be);
                check("mem_we", bus.mem_we, we_x);
                if (we_x) check("mem_wdata", bus.mem_wdata, wdo);
                check("gnt_busy", {bus.if_gnt, bus.d_gnt}, 2'b00);
                bus.mem_ready = (i == lat);
                bus.mem_rdata = (i == lat) ? word : $urandom;
                @(posedge clk); @(negedge clk);
                bus.mem_ready = 1'b0;
                if (i == lat) break;
            end
        end
        check("mem_req_resp", bus.mem_req, 1'b0);
        check("if_rvalid", bus.if_rvalid, !wd);
        check("d_rvalid", bus.d_rvalid, wd);
        cap_rd  = wd ? bus.d_rdata : bus.if_rdata;
        cap_err = wd ? bus.d_err : bus.if_err;
        check("rdata", cap_rd, exp_q.pop_front());
        check("err", cap_err, err);
        check("gnt_resp", {bus.if_gnt, bus.d_gnt}, 2'b00);
        @(posedge clk); @(negedge clk);
        check("rvalid_pulse", {bus.if_rvalid, bus.d_rvalid}, 2'b00);
    endtask

    function automatic logic [31:0] rand_addr(input bit any_off);
        logic [31:0] base;
        base = 32'($urandom_range(0, 4095)) << 2;
        if (any_off) return base | 32'($urandom_range(0, 3));
        return ($urandom_range(0, 3) == 0) ? (base | 32'($urandom_range(1, 3))) : base;
    endfunction

    function automatic logic [2:0] rand_f3(input bit we);
        logic [2:0] legal_ld [5];
        legal_ld = '{F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
        if ($urandom_range(0, 4) == 0) return 3'($urandom_range(0, 7));
        if (we) return 3'($urandom_range(0, 2));
        return legal_ld[$urandom_range(0, 4)];
    endfunction

    initial begin
        int lat;
        bus.if_req = 0; bus.if_addr = 0; bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0;
        bus.d_funct3 = 0; bus.d_wdata = 0; bus.mem_ready = 0; bus.mem_rdata = 0;
        if_pend = 0; d_pend = 0; if_a = 0; d_a = 0; d_wd = 0; d_we_v = 0; d_f3 = 0;
        last_data = 0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mem_req", bus.mem_req, 1'b0);
        check("rst_gnt", {bus.if_gnt, bus.d_gnt}, 2'b00);
        check("rst_rvalid", {bus.if_rvalid, bus.d_rvalid}, 2'b00);
        check("rst_mem_be", bus.mem_be, 4'h0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        rst = 1'b0;
        @(negedge clk);

        // First conflict after reset goes to data, then fetch, then data again
        set_fetch(32'h200); set_data(1'b0, F3_LW, 32'h400, 32'h0);
        serve(1, 32'hCAFEF00D);
        check("conflict1_data", cap_d_won, 1'b1);
        serve(2, 32'h11111111);
        check("conflict1_fetch", cap_d_won, 1'b0);
        set_fetch(32'h204); set_data(1'b0, F3_LW, 32'h404, 32'h0);
        serve(1, 32'h22222222);
        check("conflict2_data", cap_d_won, 1'b1);
        serve(1, 32'h33333333);

        set_fetch(32'h100);
        serve(1, 32'h00500093);
        check("fetch_rdata", cap_rd, 32'h00500093);
        check("fetch_addr", cap_addr, 32'h100);
        check("fetch_be", cap_be, 4'hF);
        check("fetch_err", cap_err, 1'b0);

        set_data(1'b0, F3_LB, 32'h403, 32'h0);   serve(1, 32'h80FF1234);
        check("lb_rdata", cap_rd, 32'hFFFFFF80);
        check("lb_be", cap_be, 4'hF);
        set_data(1'b0, F3_LBU, 32'h403, 32'h0);  serve(3, 32'h80FF1234);
        check("lbu_rdata", cap_rd, 32'h00000080);
        set_data(1'b0, F3_LHU, 32'h402, 32'h0);  serve(2, 32'h80FF1234);
        check("lhu_rdata", cap_rd, 32'h000080FF);

        set_data(1'b1, F3_SB, 32'h1001, 32'hAB); serve(2, 32'hDEADBEEF);
        check("sb_be", cap_be, 4'b0010);
        check("sb_wdata", cap_wdata, 32'hABABABAB);
        check("sb_we", cap_we, 1'b1);
        check("sb_addr", cap_addr, 32'h1000);
        check("sb_rdata", cap_rd, 32'h0);
        set_data(1'b1, F3_SH, 32'h1002, 32'h1234); serve(1, 32'h0);
        check("sh_be", cap_be, 4'b1100);
        check("sh_wdata", cap_wdata, 32'h12341234);

        set_data(1'b0, F3_LW, 32'h402, 32'h0);   serve(1, 32'h0);
        check("lw_mis_err", cap_err, 1'b1);
        check("lw_mis_noreq", cap_req_cycles, 0);
        set_data(1'b1, 3'b011, 32'h1000, 32'h5); serve(1, 32'h0);
        check("st_ill_err", cap_err, 1'b1);
        check("st_ill_noreq", cap_req_cycles, 0);

        set_data(1'b0, F3_LW, 32'h500, 32'h0);   serve(100, 32'h0);
        check("tmo_cycles", cap_req_cycles, TMO);
        check("tmo_err", cap_err, 1'b1);

        // Reset while the memory access is in flight
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h600; bus.d_funct3 = F3_LW;
        bus.if_req = 1'b0;
        #1 check("rstacc_gnt", bus.d_gnt, 1'b1);
        @(posedge clk); @(negedge clk);
        bus.d_req = 1'b0;
        check("rstacc_req_before", bus.mem_req, 1'b1);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        check("rstacc_mem_req", bus.mem_req, 1'b0);
        check("rstacc_rvalid", {bus.if_rvalid, bus.d_rvalid}, 2'b00);
        check("rstacc_state", 32'(dbg_state), 32'(ST_IDLE));
        rst = 1'b0;
        last_data = 1'b0;
        @(posedge clk); @(negedge clk);
        check("rstacc_rvalid_after", {bus.if_rvalid, bus.d_rvalid}, 2'b00);

        set_fetch(32'h300); set_data(1'b1, F3_SW, 32'h700, 32'h12345678);
        serve(1, 32'h0);
        check("post_rst_data", cap_d_won, 1'b1);
        serve(1, 32'h44444444);

        for (int n = 0; n < 80; n++) begin
            if (!if_pend && $urandom_range(0, 1) == 1) set_fetch(rand_addr(1'b0));
            if (!d_pend && ($urandom_range(0, 1) == 1 || !if_pend)) begin
                d_we_v = 1'($urandom_range(0, 1));
                set_data(d_we_v, rand_f3(d_we_v), rand_addr(1'b1), $urandom);
            end
            lat = ($urandom_range(0, 14) == 0) ? 20 : $urandom_range(1, 4);
            serve(lat, $urandom);
        end
        for (int n = 0; n < 2; n++) begin
            if (if_pend || d_pend) serve(1, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
